// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state and requester encodings for the memory port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arbState_e;

   typedef enum logic {REQ_FETCH = 1'b0, REQ_EXEC = 1'b1} reqId_e;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] satInc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, execute, memory and powerdown signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding pipeline/memory.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              fetchReq;
   logic [ADDR_W-1:0] fetchAddr;
   logic [DATA_W-1:0] fetchData;
   logic              fetchReady;
   logic              readReq;
   logic              writeReq;
   logic [ADDR_W-1:0] memAddrLoadStore;
   logic [DATA_W-1:0] memValueStore;
   logic [DATA_W-1:0] memValueLoad;
   logic              valueReady;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              powerdown;
   logic              pd_ack;
   logic [15:0]       fetch_grants;
   logic [15:0]       exec_grants;

   modport master (
      input  fetchReq, fetchAddr, readReq, writeReq, memAddrLoadStore, memValueStore,
             mem_rdata, powerdown,
      output fetchData, fetchReady, memValueLoad, valueReady, mem_en, mem_we, mem_addr,
             mem_wdata, pd_ack, fetch_grants, exec_grants
   );

   modport slave (
      output fetchReq, fetchAddr, readReq, writeReq, memAddrLoadStore, memValueStore,
             mem_rdata, powerdown,
      input  fetchData, fetchReady, memValueLoad, valueReady, mem_en, mem_we, mem_addr,
             mem_wdata, pd_ack, fetch_grants, exec_grants
   );

endinterface

// File: rtl/mem_arb_starve.sv
// Starvation guard: counts execute grants a waiting fetch has lost and raises
// force_fetch once the count reaches STARVE_LIMIT.
module mem_arb_starve #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic fetchReq,
   input  logic fetchGrant,
   input  logic execGrant,
   output logic force_fetch
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt_q, starveCnt_d;

   // Any idle cycle without a fetch request means nobody is being starved.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (fetchGrant || (idle && !fetchReq)) begin
         starveCnt_d = 4'd0;
      end else if (execGrant && fetchReq && (starveCnt_q != 4'hF)) begin
         starveCnt_d = starveCnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starveCnt_q <= 4'd0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

   assign force_fetch = (starveCnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and execute (execute first, with a
// fetch starvation guard). Define ARB_STATS_EN to build the saturating grant counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

   arbState_e         state_q;
   reqId_e            owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        latCnt_q;
   logic              memEn_q;
   logic              fetchReady_q;
   logic              valueReady_q;
   logic [DATA_W-1:0] fetchData_q;
   logic [DATA_W-1:0] memValueLoad_q;

   logic forceFetch;
   logic execGrant;
   logic fetchGrant;

   mem_arb_starve #(.STARVE_LIMIT(STARVE_LIMIT)) uStarve (
      .clk        (clk),
      .rst        (rst),
      .idle       (state_q == IDLE),
      .fetchReq   (bus.fetchReq),
      .fetchGrant (fetchGrant),
      .execGrant  (execGrant),
      .force_fetch(forceFetch)
   );

   // Execute normally wins; a starved fetch overrides it.
   always_comb begin
      execGrant  = 1'b0;
      fetchGrant = 1'b0;
      if ((state_q == IDLE) && !bus.powerdown) begin
         if ((bus.readReq || bus.writeReq) && !(forceFetch && bus.fetchReq)) begin
            execGrant = 1'b1;
         end else if (bus.fetchReq) begin
            fetchGrant = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         owner_q        <= REQ_FETCH;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         latCnt_q       <= 3'd0;
         memEn_q        <= 1'b0;
         fetchReady_q   <= 1'b0;
         valueReady_q   <= 1'b0;
         fetchData_q    <= '0;
         memValueLoad_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (execGrant) begin
                  owner_q <= REQ_EXEC;
                  we_q    <= bus.writeReq;
                  addr_q  <= bus.memAddrLoadStore;
                  wdata_q <= bus.memValueStore;
                  memEn_q <= 1'b1;
                  state_q <= ISSUE;
               end else if (fetchGrant) begin
                  owner_q <= REQ_FETCH;
                  we_q    <= 1'b0;
                  addr_q  <= bus.fetchAddr;
                  wdata_q <= '0;
                  memEn_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               memEn_q <= 1'b0;
               if (we_q) begin
                  valueReady_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  latCnt_q <= LAT_INIT;
                  state_q  <= WAIT;
               end
            end
            // The last WAIT cycle is the one in which the memory presents valid data.
            WAIT: begin
               if (latCnt_q == 3'd0) begin
                  if (owner_q == REQ_FETCH) begin
                     fetchData_q  <= bus.mem_rdata;
                     fetchReady_q <= 1'b1;
                  end else begin
                     memValueLoad_q <= bus.mem_rdata;
                     valueReady_q   <= 1'b1;
                  end
                  state_q <= DONE;
               end else begin
                  latCnt_q <= latCnt_q - 3'd1;
               end
            end
            DONE: begin
               fetchReady_q <= 1'b0;
               valueReady_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_en       = memEn_q;
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.fetchData    = fetchData_q;
   assign bus.fetchReady   = fetchReady_q;
   assign bus.memValueLoad = memValueLoad_q;
   assign bus.valueReady   = valueReady_q;
   assign bus.pd_ack       = rst & bus.powerdown & (state_q == IDLE);

`ifdef ARB_STATS_EN
   logic [15:0] fetchGrants_q;
   logic [15:0] execGrants_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchGrants_q <= 16'd0;
         execGrants_q  <= 16'd0;
      end else begin
         if (fetchGrant) begin
            fetchGrants_q <= satInc16(fetchGrants_q);
         end
         if (execGrant) begin
            execGrants_q <= satInc16(execGrants_q);
         end
      end
   end

   assign bus.fetch_grants = fetchGrants_q;
   assign bus.exec_grants  = execGrants_q;
`else
   assign bus.fetch_grants = 16'd0;
   assign bus.exec_grants  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a grant-order model predicts every
// memory access and ready pulse, and a monitor checks them as the DUT produces them.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int MEM_LAT      = 3;
   localparam int STARVE_LIMIT = 4;

   typedef struct {
      logic [7:0]  addr;
      int          op;
      logic [15:0] wdata;
   } reqT;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [15:0] wdata;
      int          cycle;
   } accessT;

   typedef struct {
      bit          isFetch;
      bit          isRead;
      logic [15:0] data;
      int          cycle;
   } readyT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   int cycleCount = 0;
   int expFetchGrants = 0;
   int expExecGrants = 0;
   int rdDueCycle = -1;
   logic [15:0] rdDueData;
   logic [15:0] devMem [256];
   logic [15:0] refMem [256];
   accessT accessQ [$];
   readyT  readyQ [$];
   reqT    buildF [$];
   reqT    buildE [$];
   accessT monA;
   readyT  monR;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Memory device: writes land at mem_en, read data is valid only in its due cycle.
   always @(negedge clk) begin
      if (rst && bus.mem_en) begin
         if (bus.mem_we) devMem[bus.mem_addr] = bus.mem_wdata;
         else begin
            rdDueCycle = cycleCount + MEM_LAT;
            rdDueData  = devMem[bus.mem_addr];
         end
      end
   end

   initial begin
      bus.mem_rdata = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rdata = (cycleCount == rdDueCycle) ? rdDueData : 16'($urandom);
      end
   end

   // Monitor: every mem_en and every ready pulse must match the head of its queue.
   always @(negedge clk) begin
      if (bus.mem_en) begin
         checkOutput("mem_en_expected", 32'(accessQ.size() != 0), 1);
         if (accessQ.size() != 0) begin
            monA = accessQ.pop_front();
            checkOutput("mem_addr", bus.mem_addr, monA.addr);
            checkOutput("mem_we", bus.mem_we, monA.we);
            if (monA.we) checkOutput("mem_wdata", bus.mem_wdata, monA.wdata);
            checkOutput("mem_en_cycle", cycleCount, monA.cycle);
         end
      end
      if (bus.fetchReady || bus.valueReady) begin
         checkOutput("single_ready", bus.fetchReady & bus.valueReady, 0);
         checkOutput("ready_expected", 32'(readyQ.size() != 0), 1);
         if (readyQ.size() != 0) begin
            monR = readyQ.pop_front();
            checkOutput("ready_owner_fetch", bus.fetchReady, monR.isFetch);
            checkOutput("ready_cycle", cycleCount, monR.cycle);
            if (monR.isRead && monR.isFetch) checkOutput("fetchData", bus.fetchData, monR.data);
            if (monR.isRead && !monR.isFetch) checkOutput("memValueLoad", bus.memValueLoad, monR.data);
         end
      end
   end

   task automatic waitReady(input bit isFetch);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(isFetch ? bus.fetchReady : bus.valueReady) && n < 200);
      checkOutput(isFetch ? "fetch_ready_seen" : "exec_ready_seen",
                  isFetch ? bus.fetchReady : bus.valueReady, 1);
   endtask

   task automatic driveFetch(input reqT q[$]);
      foreach (q[i]) begin
         bus.fetchReq  = 1'b1;
         bus.fetchAddr = q[i].addr;
         waitReady(1'b1);
         @(posedge clk);
         #1;
      end
      bus.fetchReq = 1'b0;
   endtask

   task automatic driveExec(input reqT q[$]);
      foreach (q[i]) begin
         bus.readReq          = (q[i].op != 1);
         bus.writeReq         = (q[i].op != 0);
         bus.memAddrLoadStore = q[i].addr;
         bus.memValueStore    = q[i].wdata;
         waitReady(1'b0);
         @(posedge clk);
         #1;
      end
      bus.readReq  = 1'b0;
      bus.writeReq = 1'b0;
   endtask

   task automatic pushAccess(input bit isFetch, input reqT t, input int enCycle, output int readyCycle);
      bit isWrite = !isFetch && (t.op != 0);
      readyCycle = enCycle + (isWrite ? 1 : 1 + MEM_LAT);
      accessQ.push_back('{t.addr, isWrite, t.wdata, enCycle});
      readyQ.push_back('{isFetch, !isWrite, isWrite ? 16'h0 : refMem[t.addr], readyCycle});
      if (isWrite) refMem[t.addr] = t.wdata;
      if (isFetch) expFetchGrants++;
      else expExecGrants++;
   endtask

   task automatic checkStats();
`ifdef ARB_STATS_EN
      checkOutput("fetch_grants", bus.fetch_grants, 32'(expFetchGrants));
      checkOutput("exec_grants", bus.exec_grants, 32'(expExecGrants));
`else
      checkOutput("fetch_grants", bus.fetch_grants, 0);
      checkOutput("exec_grants", bus.exec_grants, 0);
`endif
   endtask

   // Both requesters present their lists back to back from the same cycle; the model
   // plays out execute priority and the starvation rule to fix the grant order.
   task automatic applyStimulus(input reqT fq[$], input reqT eq[$]);
      int fi = 0;
      int ei = 0;
      int starve = 0;
      int en;
      int rdy;
      bit takeExec;
      @(posedge clk);
      #1;
      en = cycleCount + 1;
      while (fi < fq.size() || ei < eq.size()) begin
         takeExec = (ei < eq.size()) && !((fi < fq.size()) && (starve >= STARVE_LIMIT));
         if (takeExec) begin
            if (fi < fq.size()) starve = (starve >= 15) ? 15 : starve + 1;
            pushAccess(1'b0, eq[ei], en, rdy);
            ei++;
         end else begin
            starve = 0;
            pushAccess(1'b1, fq[fi], en, rdy);
            fi++;
         end
         en = rdy + 2;
      end
      fork
         driveFetch(fq);
         driveExec(eq);
      join
      repeat (2) @(posedge clk);
      #1;
      checkStats();
   endtask

   task automatic powerdownTest();
      int d;
      int rdy;
      reqT t;
      @(posedge clk);
      #1;
      t = '{8'h21, 0, 16'h0};
      pushAccess(1'b0, t, cycleCount + 1, rdy);
      bus.readReq          = 1'b1;
      bus.memAddrLoadStore = 8'h21;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.powerdown = 1'b1;
      bus.fetchReq  = 1'b1;
      bus.fetchAddr = 8'h33;
      @(negedge clk);
      checkOutput("pd_ack_busy", bus.pd_ack, 0);
      waitReady(1'b0);
      @(posedge clk);
      #1;
      bus.readReq = 1'b0;
      repeat (6) begin
         @(negedge clk);
         checkOutput("pd_ack_idle", bus.pd_ack, 1);
         @(posedge clk);
         #1;
      end
      d = cycleCount;
      bus.powerdown = 1'b0;
      t = '{8'h33, 0, 16'h0};
      pushAccess(1'b1, t, d + 1, rdy);
      @(negedge clk);
      checkOutput("pd_ack_released", bus.pd_ack, 0);
      waitReady(1'b1);
      @(posedge clk);
      #1;
      bus.fetchReq = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Reset lands in the middle of a read's WAIT; the read must vanish without a pulse.
   task automatic resetTest();
      @(posedge clk);
      #1;
      accessQ.push_back('{8'h05, 1'b0, 16'h0, cycleCount + 1});
      bus.readReq          = 1'b1;
      bus.memAddrLoadStore = 8'h05;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("rst_mem_en", bus.mem_en, 0);
      checkOutput("rst_valueReady", bus.valueReady, 0);
      checkOutput("rst_fetchReady", bus.fetchReady, 0);
      bus.readReq    = 1'b0;
      expFetchGrants = 0;
      expExecGrants  = 0;
      checkStats();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abandoned_access_left", 32'(accessQ.size()), 0);
   endtask

   initial begin
      int nf;
      int ne;
      bus.fetchReq         = 1'b0;
      bus.fetchAddr        = 8'h0;
      bus.readReq          = 1'b0;
      bus.writeReq         = 1'b0;
      bus.memAddrLoadStore = 8'h0;
      bus.memValueStore    = 16'h0;
      bus.powerdown        = 1'b0;
      for (int i = 0; i < 256; i++) begin
         devMem[i] = 16'(i * 37 + 16'h5A5A);
         refMem[i] = 16'(i * 37 + 16'h5A5A);
      end
      devMem[8'h10] = 16'h1234;
      refMem[8'h10] = 16'h1234;

      repeat (3) @(negedge clk);
      checkOutput("reset_mem_en", bus.mem_en, 0);
      checkOutput("reset_mem_we", bus.mem_we, 0);
      checkOutput("reset_mem_addr", bus.mem_addr, 0);
      checkOutput("reset_mem_wdata", bus.mem_wdata, 0);
      checkOutput("reset_fetchReady", bus.fetchReady, 0);
      checkOutput("reset_valueReady", bus.valueReady, 0);
      checkOutput("reset_fetchData", bus.fetchData, 0);
      checkOutput("reset_memValueLoad", bus.memValueLoad, 0);
      checkOutput("reset_pd_ack", bus.pd_ack, 0);
      checkStats();
      @(posedge clk);
      #2;
      rst = 1'b1;

      buildF = '{'{8'h10, 0, 16'h0}};
      buildE = '{};
      applyStimulus(buildF, buildE);

      buildF = '{};
      buildE = '{'{8'hB4, 1, 16'd45}};
      applyStimulus(buildF, buildE);

      buildE = '{'{8'h1A, 2, 16'hBEEF}, '{8'h1A, 0, 16'h0}};
      applyStimulus(buildF, buildE);

      buildF.delete();
      buildE.delete();
      for (int i = 0; i < 2; i++) buildF.push_back('{8'(8'h40 + i), 0, 16'h0});
      for (int i = 0; i < 9; i++) buildE.push_back('{8'(8'h50 + i), 0, 16'h0});
      applyStimulus(buildF, buildE);

      powerdownTest();
      resetTest();

      for (int step = 0; step < 30; step++) begin
         buildF.delete();
         buildE.delete();
         nf = $urandom_range(0, 2);
         ne = $urandom_range(0, 6);
         if (nf == 0 && ne == 0) ne = 1;
         for (int i = 0; i < nf; i++) buildF.push_back('{8'($urandom_range(0, 15)), 0, 16'h0});
         for (int i = 0; i < ne; i++)
            buildE.push_back('{8'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 16'($urandom)});
         applyStimulus(buildF, buildE);
      end

      repeat (4) @(posedge clk);
      checkOutput("access_queue_drained", 32'(accessQ.size()), 0);
      checkOutput("ready_queue_drained", 32'(readyQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
